countdown100: RTL

- Loadable modulo-100 down-counter. It is the reverse-direction companion to the team's up-counting count100 block.
- Used as a frame/line countdown timer in the image-processing pipeline.
- Exposes the binary count and a two-digit BCD view (tens/ones) for display.
- Uses a start/busy/done handshake toward the controlling sequencer.

---
 rtl/countdown100_pkg.sv | 35 +++
 rtl/countdown100_if.sv | 40 ++++
 rtl/countdown100_bcd_down_digit.sv | 36 +++
 rtl/countdown100.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/countdown100_pkg.sv
// ---------------------------------------------------------------------------
// count100_pkg
// Shared definitions for the count100 family (count100 / countdown100):
//   - default width and modulo of the counter
//   - BCD digit width
//   - FSM state type used by countdown100
//   - two-digit BCD helper used when a binary value is loaded
// ---------------------------------------------------------------------------
package count100_pkg;

    localparam int MODULO_DEFAULT = 100;
    localparam int WIDTH_DEFAULT  = 8;
    localparam int BCD_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } cd_state_t;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    // Split a value below 100 into decimal digits. This is only used on
    // load/reload; the running count is decremented digit-wise.
    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t r;
        r.tens = BCD_W'((v / 10) % 10);
        r.ones = BCD_W'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/countdown100_if.sv
// ---------------------------------------------------------------------------
// countdown100_if
// Sequencer-side bundle of countdown100.
//   master : controlling sequencer (drives start/load_val/pause/stop)
//   slave  : countdown100 (drives count/tens/ones/busy/done)
// Signals:
//   start     level request to load and begin counting (honoured in IDLE)
//   load_val  start value, sampled when start is accepted
//   pause     hold the count while high
//   stop      abort back to IDLE without done
//   count     binary count
//   tens/ones BCD view of count
//   busy      high while counting or paused
//   done      one-cycle pulse on terminal count
// ---------------------------------------------------------------------------
interface countdown100_if import count100_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    logic             busy;
    logic             done;

    modport master (
        output start, load_val, pause, stop,
        input  count, tens, ones, busy, done
    );

    modport slave (
        input  start, load_val, pause, stop,
        output count, tens, ones, busy, done
    );

endinterface

// File: rtl/countdown100_bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
// One BCD decade of a down-counter.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset (value -> 0)
//   load        load load_val (has priority over dec_en)
//   load_val    digit value to load, 0..9
//   dec_en      decrement this digit; 0 wraps to 9
//   value       current digit
//   borrow_out  high when dec_en and value==0, i.e. the next decade
//               must decrement on this edge
// ---------------------------------------------------------------------------
module bcd_down_digit import count100_pkg::*; (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec_en,
    output logic [BCD_W-1:0] value,
    output logic             borrow_out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec_en) begin
            value <= (value == '0) ? BCD_W'(9) : value - BCD_W'(1);
        end
    end

    assign borrow_out = dec_en && (value == '0);

endmodule

// File: rtl/countdown100.sv
// ---------------------------------------------------------------------------
// countdown100
// Loadable modulo-100 down-counter with binary and two-digit BCD outputs,
// used as a frame/line countdown timer. Start/busy/done handshake toward
// the sequencer; pause freezes the count, stop aborts without done.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    countdown100_if.slave (start, load_val, pause, stop in;
//          count, tens, ones, busy, done out)
//
// Build option:
//   COUNTDOWN100_AUTO_RELOAD_EN  when defined, terminal count pulses done
//   and reloads the latched value in the same edge, staying in RUN until
//   stop or reset. Undefined: terminal count returns to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; count holds its last value
// RUN   | decrementing once per edge; terminal at count==0
// HOLD  | paused; count frozen until pause drops or stop
// ---------------------------------------------------------------------------
module countdown100 import count100_pkg::*; #(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int MODULO = MODULO_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    countdown100_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    cd_state_t        state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] latched_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] load_clip;
    logic             accept;
    logic             at_zero;
    logic             run_go;
    logic             dec_en;
    logic             reload;
    logic             digit_load;
    bcd2_t            load_bcd;

    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] ones_q;
    logic             ones_borrow;
    logic             unused_tens_borrow;

    assign load_clip = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    assign accept    = (state == IDLE) && bus.start;
    assign at_zero   = (count_q == '0);

    // RUN edge that is neither stopped nor paused: either a decrement or
    // the terminal-count edge.
    assign run_go    = (state == RUN) && !bus.stop && !bus.pause;
    assign dec_en    = run_go && !at_zero;

`ifdef COUNTDOWN100_AUTO_RELOAD_EN
    assign reload    = run_go && at_zero;
`else
    assign reload    = 1'b0;
`endif

    // Digits only need a binary->BCD conversion on load/reload; the running
    // count is tracked digit-wise so tens/ones never lag count.
    assign digit_load = accept || reload;
    assign load_bcd   = to_bcd2(32'(accept ? load_clip : latched_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count_q   <= '0;
            latched_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count_q   <= load_clip;
                        latched_q <= load_clip;
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.pause) begin
                        state  <= HOLD;
                    end else if (at_zero) begin
                        done_q <= 1'b1;
`ifdef COUNTDOWN100_AUTO_RELOAD_EN
                        count_q <= latched_q;
`else
                        busy_q  <= 1'b0;
                        state   <= IDLE;
`endif
                    end else begin
                        count_q <= count_q - WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (bus.stop) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (!bus.pause) begin
                        // Resume edge only changes state; the next edge decrements.
                        state  <= RUN;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    bcd_down_digit u_ones (
        .clk        (clk),
        .reset      (reset),
        .load       (digit_load),
        .load_val   (load_bcd.ones),
        .dec_en     (dec_en),
        .value      (ones_q),
        .borrow_out (ones_borrow)
    );

    // The count never goes below 0, so the tens borrow has no consumer.
    bcd_down_digit u_tens (
        .clk        (clk),
        .reset      (reset),
        .load       (digit_load),
        .load_val   (load_bcd.tens),
        .dec_en     (ones_borrow),
        .value      (tens_q),
        .borrow_out (unused_tens_borrow)
    );

    assign bus.count = count_q;
    assign bus.tens  = tens_q;
    assign bus.ones  = ones_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
